// File: rtl/jtype_pkg.sv
// Shared J-type constants and the immediate packer; the decode-side
// immediate extraction imports the same package.
package jtype_pkg;

  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [31:0] INSTR_NOP    = 32'h00000013;
  localparam int          ERR_MISALIGN = 0;
  localparam int          ERR_RANGE    = 1;
  localparam int          J_IMM_MIN    = -1048576;
  localparam int          J_IMM_MAX    = 1048574;
  localparam int          Q_PAYLOAD_W  = 34;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  // Scatter the byte offset into J-type immediate bit order.
  function automatic logic [31:0] pack_jal(input logic [4:0] rd, input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/jenc_skid_q.sv
// Two-entry in-order valid/ready queue. The head register drives the
// output directly, so the payload is stable while the consumer stalls.
module jenc_skid_q
  import jtype_pkg::*;
#(
  parameter int W = Q_PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output q_state_e     state
);

  // Handshake contract: a transfer happens on a rising edge where valid
  // and ready are both high; ready/valid derive only from the state register.
  q_state_e     state_next;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;
  logic         load_head;
  logic         load_tail;
  logic         head_from_tail;

  assign push     = in_valid && (state != Q_FULL);
  assign pop      = out_ready && (state != Q_EMPTY);
  assign out_data = head;

  always_comb begin
    state_next     = state;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    case (state)
      Q_EMPTY: begin
        if (push) begin
          load_head  = 1'b1;
          state_next = Q_ONE;
        end
      end
      Q_ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          load_tail  = 1'b1;
          state_next = Q_FULL;
        end else if (pop) begin
          state_next = Q_EMPTY;
        end
      end
      Q_FULL: begin
        if (pop) begin
          head_from_tail = 1'b1;
          state_next     = Q_ONE;
        end
      end
      default: state_next = Q_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= Q_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      if (load_head) head <= in_data;
      else if (head_from_tail) head <= tail;
      if (load_tail) tail <= in_data;
    end
  end

endmodule

// File: rtl/jal_encoder.sv
// JAL encoder: checks offset alignment and range, packs the J-type
// instruction, and queues {err, instr} for the consumer.
module jal_encoder
  import jtype_pkg::*;
#(
  parameter int ALLOW_RVC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  q_state_e         q_state;
  logic [1:0]       enc_err;
  logic [31:0]      enc_instr;
  logic [33:0]      q_out;
  logic             accept;

  always_comb begin
    enc_err = 2'b00;
    if (ALLOW_RVC != 0) enc_err[ERR_MISALIGN] = in_offset[0];
    else                enc_err[ERR_MISALIGN] = |in_offset[1:0];
    // Offset must fit the 21-bit signed immediate: upper bits all sign.
    enc_err[ERR_RANGE] = !((&in_offset[31:20]) || !(|in_offset[31:20]));
    enc_instr = (enc_err == 2'b00) ? pack_jal(in_rd, in_offset) : INSTR_NOP;
  end

  assign in_ready  = (q_state != Q_FULL);
  assign out_valid = (q_state != Q_EMPTY);
  assign accept    = in_valid && in_ready;
  assign out_instr = q_out[31:0];
  assign out_err   = q_out[33:32];

  jenc_skid_q #(.W(Q_PAYLOAD_W)) u_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   ({enc_err, enc_instr}),
    .out_ready (out_ready),
    .out_data  (q_out),
    .state     (q_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (cnt_clr) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (accept) begin
      if (enc_err == 2'b00) begin
        if (cnt_ok != CNT_MAX) cnt_ok <= cnt_ok + 1'b1;
      end else begin
        if (cnt_err != CNT_MAX) cnt_err <= cnt_err + 1'b1;
      end
    end
  end

endmodule

// File: doc/jal_encoder.md
Name: jal_encoder

Overview:
- Encodes a JAL (J-type) instruction from a destination register and a signed byte offset. This is the inverse of the J-type immediate extraction in the decode path.
- Validates offset alignment and range, then packs the immediate into RV32I J-type bit order.
- Buffers results in a 2-entry output queue with valid/ready handshakes on both sides.
- Consumers are the self-test instruction generator and the trampoline/patch writer.

Parameters:
- ALLOW_RVC, 1, 1 = halfword alignment suffices (offset[0] must be 0); 0 = word alignment required (offset[1:0] must be 0).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_rd  in  5  destination register index.
- in_offset  in  32  signed byte offset, two's complement.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_instr  out  32  encoded instruction.
- out_err  out  2  bit0 = misaligned, bit1 = out of range.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_ok  out  CNT_W  count of requests accepted with no error.
- cnt_err  out  CNT_W  count of requests accepted with any error.

Behaviour:
- Reset (async assert, sync release): queue empty, out_valid=0, out_instr=0, out_err=0, in_ready=1, cnt_ok=0, cnt_err=0. Any in-flight request is discarded.
- Accept: an input handshake occurs when in_valid && in_ready. The request is encoded combinationally and pushed into the queue in the same cycle.
- Latency: an accepted request appears on out_valid the next cycle at the earliest.
- Misaligned check:
  - ALLOW_RVC=1: misaligned when offset[0]=1.
  - ALLOW_RVC=0: misaligned when offset[1:0]!=0.
- Range check: out of range unless -1048576 <= offset <= 1048574, i.e. offset[31:20] is all 0 or all 1.
- Encoding, no error: instr = {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111}.
- Encoding, any error: instr = 32'h00000013 (NOP), with out_err carrying the error bits. Both error bits may be set together.
- Queue: 2 entries, in-order.
  - in_ready = (occupancy < 2), registered from occupancy.
  - Push only: occupancy +1. Pop only (out_valid && out_ready): occupancy -1.
  - Push and pop in the same cycle: occupancy unchanged; gives throughput of 1 per cycle at occupancy 1.
  - Full: in_ready=0, no push. A pop frees a slot and in_ready rises the next cycle.
  - Empty: out_valid=0. out_instr/out_err hold their last value and are don't-care.
- Output stability: while out_valid && !out_ready, out_instr and out_err must not change.
- Counters: increment on input handshake, cnt_ok when out_err==0 and cnt_err otherwise. Both saturate at 2^CNT_W-1.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- in_rd = 0 is legal (plain jump) and is not an error.

Decomposition:
- Package jtype_pkg holds: OPC_JAL=7'b1101111, INSTR_NOP=32'h00000013, ERR_MISALIGN=0, ERR_RANGE=1, and the J_IMM_MIN/J_IMM_MAX constants. The decode-side immediate logic shares this package.
- Sub-module jenc_skid_q: generic 2-entry valid/ready queue, payload width 34 (instr + err). Top level contains the combinational packer, the checks and the counters.

Test Plan:
- rd=1, offset=+8, out_ready=1 -> out_instr=32'h008000EF, out_err=0, one cycle after accept; cnt_ok=1.
- rd=0, offset=-4 -> 32'hFFDFF06F, err=0. rd=5, offset=32'h000FFFFE -> 32'h7FFFF2EF. offset=32'hFFF00000 (min), rd=0 -> 32'h8000006F.
- offset=32'h00100000 -> 32'h00000013, err=2'b10. offset=3 -> NOP, err=2'b01. offset=32'h00100001 -> err=2'b11. cnt_err increments each time.
- ALLOW_RVC=0, offset=2 -> err=2'b01. Same offset with ALLOW_RVC=1 -> valid encoding 32'h0020006F (rd=0).
- Backpressure:
  - out_ready=0, offer 3 back-to-back requests -> 2 accepted, then in_ready=0 and out_instr is stable.
  - Raise out_ready -> entries emerge in order, third request accepted one cycle after the first pop.
  - Continuous valid/ready at occupancy 1 -> 1 result per cycle.
- Reset and counters:
  - Assert rst_n low mid-stream with 2 entries queued -> out_valid=0 immediately, counters 0, in_ready=1 after release.
  - cnt_clr in the same cycle as an accept -> counter reads 0.
  - Saturation check with CNT_W=2: 5 accepts -> cnt_ok=3.
